regfile_port_sched: RTL and testbench

//  Schedules the single shared port of the 33-entry register file (32 GPRs plus PC at entry 32) between

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_port_sched_if.sv | 48 ++++
 rtl/regfile_port_sched.sv | 108 ++++++++++
 tb/tb_regfile_port_sched.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file port scheduler.
// Holds the scheduler state encoding and register-file geometry.
package regfile_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        RD_C,
        RESP
    } sched_state_e;

    localparam int NUM_GPR   = 32;
    localparam int PC_ADDR   = 32;
    localparam int GPR_IDX_W = 5;

endpackage

// File: rtl/regfile_port_sched_if.sv
// Bundle of all scheduler channels: operand read request/response,
// writeback, PC update and the register-file port itself.
// slave  : the scheduler's view.
// master : the pipeline + register-file view.
interface regfile_port_sched_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic                  rd_valid;
    logic                  rd_ready;
    logic [4:0]            rd_rs1;
    logic [4:0]            rd_rs2;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rs1_data;
    logic [DATA_WIDTH-1:0] rsp_rs2_data;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [4:0]            wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  pc_valid;
    logic                  pc_ready;
    logic [DATA_WIDTH-1:0] pc_data;
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic                  rf_wen;
    logic                  rf_ren;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic [DATA_WIDTH-1:0] rf_rdata;

    modport slave (
        input  rd_valid, rd_rs1, rd_rs2, rsp_ready,
        input  wb_valid, wb_rd, wb_data,
        input  pc_valid, pc_data, rf_rdata,
        output rd_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data,
        output wb_ready, pc_ready,
        output rf_addr, rf_wen, rf_ren, rf_wdata
    );

    modport master (
        output rd_valid, rd_rs1, rd_rs2, rsp_ready,
        output wb_valid, wb_rd, wb_data,
        output pc_valid, pc_data, rf_rdata,
        input  rd_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data,
        input  wb_ready, pc_ready,
        input  rf_addr, rf_wen, rf_ren, rf_wdata
    );

endinterface

// File: rtl/regfile_port_sched.sv
// Arbitrates the single register-file port between operand reads,
// GPR writeback and PC update.
// Ports: clk, rst_n (async active-low), bus (regfile_port_sched_if.slave).
module regfile_port_sched #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int PC_ADDR    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_port_sched_if.slave  bus
);
    import regfile_pkg::*;

    localparam int PAD_W = ADDR_WIDTH - GPR_IDX_W;

    sched_state_e          r_state;
    logic                  r_starve;
    logic [4:0]            r_rs1;
    logic [4:0]            r_rs2;
    logic [DATA_WIDTH-1:0] r_rs1_data;
    logic [DATA_WIDTH-1:0] r_rs2_data;

    logic w_rd_grant;
    logic w_wr_ok;
    logic w_wb_go;
    logic w_pc_go;
    logic w_wb_wen;
    logic w_rd_port;

    // Reads only start in IDLE; a denied read sets starve so it wins
    // the next IDLE cycle regardless of pending writes.
    always_comb begin
        w_rd_grant = rst_n && (r_state == IDLE) && bus.rd_valid &&
                     (r_starve || !(bus.wb_valid || bus.pc_valid));
        w_rd_port  = (r_state == RD_A) || (r_state == RD_B);
        w_wr_ok    = rst_n && !w_rd_port && !w_rd_grant;
        w_wb_go    = w_wr_ok && bus.wb_valid;
        w_pc_go    = w_wr_ok && bus.pc_valid && !bus.wb_valid;
        // x0 writes consume the slot but never reach the file
        w_wb_wen   = w_wb_go && (bus.wb_rd != 5'd0);
    end

    always_comb begin
        bus.rd_ready     = w_rd_grant;
        bus.wb_ready     = w_wb_go;
        bus.pc_ready     = w_pc_go;
        bus.rf_ren       = w_rd_port;
        bus.rf_wen       = w_wb_wen || w_pc_go;
        bus.rsp_valid    = (r_state == RESP);
        bus.rsp_rs1_data = r_rs1_data;
        bus.rsp_rs2_data = r_rs2_data;
        bus.rf_addr      = '0;
        bus.rf_wdata     = '0;
        unique case (1'b1)
            r_state == RD_A: bus.rf_addr = {{PAD_W{1'b0}}, r_rs1};
            r_state == RD_B: bus.rf_addr = {{PAD_W{1'b0}}, r_rs2};
            w_wb_wen: begin
                bus.rf_addr  = {{PAD_W{1'b0}}, bus.wb_rd};
                bus.rf_wdata = bus.wb_data;
            end
            w_pc_go: begin
                bus.rf_addr  = ADDR_WIDTH'(PC_ADDR);
                bus.rf_wdata = bus.pc_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_starve   <= 1'b0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rd_grant) begin
                        r_state  <= RD_A;
                        r_starve <= 1'b0;
                        r_rs1    <= bus.rd_rs1;
                        r_rs2    <= bus.rd_rs2;
                    end else if (bus.rd_valid) begin
                        r_starve <= 1'b1;
                    end
                end
                RD_A: r_state <= RD_B;
                RD_B: begin
                    // rdata here answers the RD_A read of rs1
                    r_rs1_data <= (r_rs1 == 5'd0) ? '0 : bus.rf_rdata;
                    r_state    <= RD_C;
                end
                RD_C: begin
                    r_rs2_data <= (r_rs2 == 5'd0) ? '0 : bus.rf_rdata;
                    r_state    <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_port_sched.sv
// Directed testbench for regfile_port_sched.
// Models the register file with one-cycle read latency.
module tb_regfile_port_sched;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_port_sched_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

    regfile_port_sched #(
        .ADDR_WIDTH(6),
        .DATA_WIDTH(32),
        .PC_ADDR(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    logic [31:0] mem [64];
    logic        bd_we;
    logic [5:0]  bd_addr;
    logic [31:0] bd_data;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (bus.rf_wen) mem[bus.rf_addr] <= bus.rf_wdata;
        if (bus.rf_ren) bus.rf_rdata <= mem[bus.rf_addr];
    end

    int nvec = 0;
    int nfail = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        bus.rd_valid  = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.pc_valid  = 1'b0;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic do_wb(input logic [4:0] rd, input logic [31:0] d);
        int n;
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_data  = d;
        #1;
        n = 0;
        while (bus.wb_ready !== 1'b1 && n < 10) begin
            tick;
            n++;
        end
        nvec++;
        if (bus.wb_ready !== 1'b1) begin
            nfail++;
            $display("FAIL wb_timeout rd=%0d got wb_ready=%b want 1", rd, bus.wb_ready);
        end
        nvec++;
        if (bus.rf_wen !== 1'b1 || bus.rf_addr !== {1'b0, rd} ||
            bus.rf_wdata !== d) begin
            nfail++;
            $display("FAIL wb_port got wen=%b addr=%0d wd=%h want 1/%0d/%h",
                     bus.rf_wen, bus.rf_addr, bus.rf_wdata, rd, d);
        end
        tick;
        bus.wb_valid = 1'b0;
        #1;
    endtask

    task automatic start_read(input logic [4:0] rs1, input logic [4:0] rs2);
        bus.rd_valid = 1'b1;
        bus.rd_rs1   = rs1;
        bus.rd_rs2   = rs2;
        #1;
        nvec++;
        if (bus.rd_ready !== 1'b1) begin
            nfail++;
            $display("FAIL rd_grant got %b want 1", bus.rd_ready);
        end
    endtask

    // Called in the grant cycle; walks the read through to the handshake.
    task automatic run_read(input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] e1, input logic [31:0] e2);
        tick;
        quiet;
        #1;
        nvec++;
        if (bus.rf_ren !== 1'b1 || bus.rf_addr !== {1'b0, rs1} ||
            bus.rf_wen !== 1'b0 || bus.rd_ready !== 1'b0) begin
            nfail++;
            $display("FAIL rd_a got ren=%b addr=%0d wen=%b rdy=%b want 1/%0d/0/0",
                     bus.rf_ren, bus.rf_addr, bus.rf_wen, bus.rd_ready, rs1);
        end
        tick;
        nvec++;
        if (bus.rf_ren !== 1'b1 || bus.rf_addr !== {1'b0, rs2}) begin
            nfail++;
            $display("FAIL rd_b got ren=%b addr=%0d want 1/%0d",
                     bus.rf_ren, bus.rf_addr, rs2);
        end
        tick;
        nvec++;
        if (bus.rf_ren !== 1'b0 || bus.rsp_valid !== 1'b0 ||
            bus.rf_addr !== 6'd0) begin
            nfail++;
            $display("FAIL rd_c got ren=%b rsp_valid=%b addr=%0d want 0/0/0",
                     bus.rf_ren, bus.rsp_valid, bus.rf_addr);
        end
        tick;
        nvec++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rs1_data !== e1 ||
            bus.rsp_rs2_data !== e2) begin
            nfail++;
            $display("FAIL rsp got v=%b %h/%h want 1 %h/%h", bus.rsp_valid,
                     bus.rsp_rs1_data, bus.rsp_rs2_data, e1, e2);
        end
        bus.rsp_ready = 1'b1;
        tick;
        bus.rsp_ready = 1'b0;
        #1;
        nvec++;
        if (bus.rsp_valid !== 1'b0) begin
            nfail++;
            $display("FAIL rsp_done got rsp_valid=%b want 0", bus.rsp_valid);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        quiet;
        bus.rd_valid = 1'b1;
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd4;
        bus.wb_data  = 32'h1;
        bus.rd_rs1   = 5'd1;
        bus.rd_rs2   = 5'd2;
        bus.pc_data  = '0;
        bd_we        = 1'b0;
        bd_addr      = '0;
        bd_data      = '0;
        #2;
        nvec++;
        if (bus.rsp_valid !== 1'b0 || bus.rd_ready !== 1'b0 ||
            bus.wb_ready !== 1'b0 || bus.rf_wen !== 1'b0 ||
            bus.rf_ren !== 1'b0 || bus.rf_addr !== 6'd0 ||
            bus.rsp_rs1_data !== 32'd0 || bus.rsp_rs2_data !== 32'd0) begin
            nfail++;
            $display("FAIL reset got v=%b rr=%b wr=%b wen=%b ren=%b a=%0d d=%h/%h",
                     bus.rsp_valid, bus.rd_ready, bus.wb_ready, bus.rf_wen,
                     bus.rf_ren, bus.rf_addr, bus.rsp_rs1_data, bus.rsp_rs2_data);
        end
        tick;
        tick;
        quiet;
        rst_n = 1'b1;
        #1;
        bd_we   = 1'b1;
        bd_addr = 6'd0;
        bd_data = 32'hDEAD_BEEF;
        tick;
        bd_we = 1'b0;
        do_wb(5'd3, 32'h11);
        do_wb(5'd7, 32'h22);
        do_wb(5'd5, 32'hAB);
    endtask

    task automatic test_read;
        start_read(5'd3, 5'd7);
        run_read(5'd3, 5'd7, 32'h11, 32'h22);
    endtask

    task automatic test_x0;
        start_read(5'd0, 5'd5);
        run_read(5'd0, 5'd5, 32'h0, 32'hAB);
    endtask

    task automatic test_contention;
        bus.rd_valid = 1'b1;
        bus.rd_rs1   = 5'd9;
        bus.rd_rs2   = 5'd3;
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd9;
        bus.wb_data  = 32'h99;
        #1;
        nvec++;
        if (bus.wb_ready !== 1'b1 || bus.rd_ready !== 1'b0 ||
            bus.rf_wen !== 1'b1 || bus.rf_addr !== 6'd9) begin
            nfail++;
            $display("FAIL cont_wb got wr=%b rr=%b wen=%b a=%0d want 1/0/1/9",
                     bus.wb_ready, bus.rd_ready, bus.rf_wen, bus.rf_addr);
        end
        tick;
        bus.pc_valid = 1'b1;
        bus.pc_data  = 32'h4;
        #1;
        nvec++;
        if (bus.rd_ready !== 1'b1 || bus.wb_ready !== 1'b0 ||
            bus.pc_ready !== 1'b0 || bus.rf_wen !== 1'b0) begin
            nfail++;
            $display("FAIL cont_starve got rr=%b wr=%b pr=%b wen=%b want 1/0/0/0",
                     bus.rd_ready, bus.wb_ready, bus.pc_ready, bus.rf_wen);
        end
        run_read(5'd9, 5'd3, 32'h99, 32'h11);
    endtask

    task automatic test_priority;
        start_read(5'd3, 5'd7);
        tick;
        quiet;
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd3;
        bus.wb_data  = 32'h55;
        bus.pc_valid = 1'b1;
        bus.pc_data  = 32'h1234;
        #1;
        nvec++;
        if (bus.wb_ready !== 1'b0 || bus.pc_ready !== 1'b0 ||
            bus.rf_wen !== 1'b0 || bus.rf_ren !== 1'b1) begin
            nfail++;
            $display("FAIL pri_rda got wr=%b pr=%b wen=%b ren=%b want 0/0/0/1",
                     bus.wb_ready, bus.pc_ready, bus.rf_wen, bus.rf_ren);
        end
        tick;
        tick;
        nvec++;
        if (bus.wb_ready !== 1'b1 || bus.pc_ready !== 1'b0 ||
            bus.rf_wen !== 1'b1 || bus.rf_addr !== 6'd3 ||
            bus.rf_wdata !== 32'h55) begin
            nfail++;
            $display("FAIL pri_rdc got wr=%b pr=%b wen=%b a=%0d wd=%h want 1/0/1/3/55",
                     bus.wb_ready, bus.pc_ready, bus.rf_wen, bus.rf_addr, bus.rf_wdata);
        end
        tick;
        bus.wb_valid = 1'b0;
        #1;
        nvec++;
        if (bus.pc_ready !== 1'b1 || bus.rf_wen !== 1'b1 ||
            bus.rf_addr !== 6'd32 || bus.rf_wdata !== 32'h1234 ||
            bus.rsp_valid !== 1'b1 || bus.rsp_rs1_data !== 32'h11 ||
            bus.rsp_rs2_data !== 32'h22) begin
            nfail++;
            $display("FAIL pri_resp got pr=%b wen=%b a=%0d v=%b d=%h/%h want 1/1/32/1 11/22",
                     bus.pc_ready, bus.rf_wen, bus.rf_addr, bus.rsp_valid,
                     bus.rsp_rs1_data, bus.rsp_rs2_data);
        end
        tick;
        bus.pc_valid  = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        nvec++;
        if (bus.rsp_rs1_data !== 32'h11 || mem[3] !== 32'h55 ||
            mem[32] !== 32'h1234) begin
            nfail++;
            $display("FAIL pri_after got d1=%h x3=%h pc=%h want 11/55/1234",
                     bus.rsp_rs1_data, mem[3], mem[32]);
        end
        tick;
        bus.rsp_ready = 1'b0;
        #1;
    endtask

    task automatic test_writes;
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd0;
        bus.wb_data  = 32'hFFFF;
        #1;
        nvec++;
        if (bus.wb_ready !== 1'b1 || bus.rf_wen !== 1'b0 ||
            bus.rf_addr !== 6'd0 || bus.rf_wdata !== 32'd0) begin
            nfail++;
            $display("FAIL wr_x0 got wr=%b wen=%b a=%0d wd=%h want 1/0/0/0",
                     bus.wb_ready, bus.rf_wen, bus.rf_addr, bus.rf_wdata);
        end
        tick;
        bus.wb_valid = 1'b0;
        bus.pc_valid = 1'b1;
        bus.pc_data  = 32'h8000_0004;
        #1;
        nvec++;
        if (bus.pc_ready !== 1'b1 || bus.rf_wen !== 1'b1 ||
            bus.rf_addr !== 6'd32 || bus.rf_wdata !== 32'h8000_0004) begin
            nfail++;
            $display("FAIL wr_pc got pr=%b wen=%b a=%0d wd=%h want 1/1/32/80000004",
                     bus.pc_ready, bus.rf_wen, bus.rf_addr, bus.rf_wdata);
        end
        tick;
        bus.pc_valid = 1'b0;
        #1;
        nvec++;
        if (mem[32] !== 32'h8000_0004 || mem[0] !== 32'hDEAD_BEEF) begin
            nfail++;
            $display("FAIL wr_mem got pc=%h x0slot=%h want 80000004/deadbeef",
                     mem[32], mem[0]);
        end
    endtask

    task automatic test_backpressure;
        start_read(5'd5, 5'd7);
        tick;
        quiet;
        tick;
        tick;
        tick;
        bus.rd_valid = 1'b1;
        bus.rd_rs1   = 5'd3;
        bus.rd_rs2   = 5'd5;
        for (int i = 0; i < 5; i++) begin
            bus.wb_valid = (i % 2 == 0);
            bus.wb_rd    = 5'(10 + i);
            bus.wb_data  = 32'(i);
            bus.pc_valid = 1'b1;
            bus.pc_data  = 32'h100 + 32'(i);
            #1;
            nvec++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rs1_data !== 32'hAB ||
                bus.rsp_rs2_data !== 32'h22 || bus.rd_ready !== 1'b0 ||
                bus.rf_wen !== 1'b1 || bus.wb_ready !== (i % 2 == 0) ||
                bus.pc_ready !== (i % 2 != 0)) begin
                nfail++;
                $display("FAIL bp[%0d] got v=%b d=%h/%h rr=%b wen=%b wr=%b pr=%b",
                         i, bus.rsp_valid, bus.rsp_rs1_data, bus.rsp_rs2_data,
                         bus.rd_ready, bus.rf_wen, bus.wb_ready, bus.pc_ready);
            end
            tick;
        end
        bus.wb_valid  = 1'b0;
        bus.pc_valid  = 1'b0;
        bus.rsp_ready = 1'b1;
        tick;
        bus.rsp_ready = 1'b0;
        #1;
        nvec++;
        if (bus.rd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            nfail++;
            $display("FAIL b2b got rr=%b v=%b want 1/0", bus.rd_ready, bus.rsp_valid);
        end
        run_read(5'd3, 5'd5, 32'h55, 32'hAB);
    endtask

    task automatic test_reset_mid;
        int seen;
        start_read(5'd3, 5'd7);
        tick;
        quiet;
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        nvec++;
        if (bus.rsp_valid !== 1'b0 || bus.rf_ren !== 1'b0 ||
            bus.rf_addr !== 6'd0) begin
            nfail++;
            $display("FAIL rst_mid got v=%b ren=%b a=%0d want 0/0/0",
                     bus.rsp_valid, bus.rf_ren, bus.rf_addr);
        end
        tick;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus.rsp_valid !== 1'b0 || bus.rf_ren !== 1'b0) seen++;
            tick;
        end
        nvec++;
        if (seen != 0) begin
            nfail++;
            $display("FAIL rst_norsp got %0d active cycles want 0", seen);
        end
        start_read(5'd5, 5'd3);
        run_read(5'd5, 5'd3, 32'hAB, 32'h55);
    endtask

    initial begin
        test_reset;
        test_read;
        test_x0;
        test_contention;
        test_priority;
        test_writes;
        test_backpressure;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
